alu_muldiv: RTL

Multi-cycle multiply/divide unit. It is the parametrised, sequential successor to the combinational ALU/ALU_control pair.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, using iterative shift-add and restoring division with a start/busy/done handshake.
- Sits beside the ALU in the EX stage. The pipeline stalls on busy and reads HI/LO for mfhi/mflo.

---
 rtl/alu_muldiv.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit: iterative shift-add multiply and restoring
// division on operand magnitudes, with sign fix-up before HI/LO are written.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, next_state;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag_b;
  logic [CNT_W-1:0]     count;
  logic                 is_div, neg_q, neg_r, dz;

  logic                 is_signed, sa, sb, b_zero, dz_in;
  logic [WIDTH-1:0]     mag_a_in, mag_b_in;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   step_next, prod_neg;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    is_signed = ~op[0];
    sa        = is_signed & a[WIDTH-1];
    sb        = is_signed & b[WIDTH-1];
    mag_a_in  = sa ? '0 - a : a;
    mag_b_in  = sb ? '0 - b : b;
    b_zero    = (b == '0);
    dz_in     = op[1] & b_zero;

    // prod holds {partial, multiplier} for multiply and {remainder, quotient} for divide
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_b} : '0);
    div_diff  = prod[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    if (is_div)
      step_next = div_diff[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    else
      step_next = {mul_sum, prod[WIDTH-1:1]};

    prod_neg  = '0 - prod;
    quo       = neg_q ? '0 - prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem       = neg_r ? '0 - prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = dz_in ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (count == CNT_W'(1)) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod        <= '0;
      mag_b       <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            dz          <= dz_in;
            div_by_zero <= 1'b0;
            count       <= CNT_W'(WIDTH);
            mag_b       <= mag_b_in;
            // Divide-by-zero preloads the final HI/LO so FIX just copies them out
            prod        <= dz_in ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a_in};
          end else begin
            if (mt_hi) hi <= wdata;
            if (mt_lo) lo <= wdata;
          end
        end
        CALC: begin
          count <= count - CNT_W'(1);
          prod  <= step_next;
        end
        FIX: begin
          done <= 1'b1;
          if (dz) begin
            hi          <= prod[2*WIDTH-1:WIDTH];
            lo          <= prod[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else if (neg_q) begin
            hi <= prod_neg[2*WIDTH-1:WIDTH];
            lo <= prod_neg[WIDTH-1:0];
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
